// File: rtl/poly_term_sequencer_if.sv
// Handshake/control bundle between top-level control, the term sequencer
// and the constant/function/accumulator datapath.
interface poly_term_sequencer_if #(
  parameter int CONST_W = 3,
  parameter int FUN_W   = 2
);
  logic               start;
  logic               abort;
  logic               op_ack;
  logic               busy;
  logic               done;
  logic               err;
  logic               op_valid;
  logic               acc_clr;
  logic               acc_en;
  logic [CONST_W-1:0] sel_const;
  logic [FUN_W-1:0]   sel_fun;
  logic               sel_acum;
  logic [2:0]         term_idx;

  // Control / datapath side.
  modport master (
    output start, abort, op_ack,
    input  busy, done, err, op_valid, acc_clr, acc_en,
    input  sel_const, sel_fun, sel_acum, term_idx
  );

  // Sequencer side.
  modport slave (
    input  start, abort, op_ack,
    output busy, done, err, op_valid, acc_clr, acc_en,
    output sel_const, sel_fun, sel_acum, term_idx
  );
endinterface

// File: rtl/poly_term_sequencer.sv
// Term sequencer for the N-term series evaluation datapath.
// Steps CLEAR -> (ISSUE -> WAIT -> ACCUM) x N_TERMS -> DONE under a
// start/done handshake with an op_valid/op_ack exchange per term.
// Optional build macro WATCHDOG_EN adds a WAIT timeout, an ERROR state
// and the sticky err flag; without it err is constant 0.
module poly_term_sequencer #(
  parameter int N_TERMS = 6,
  parameter int CONST_W = 3,
  parameter int FUN_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  poly_term_sequencer_if.slave  bus
);

  if (N_TERMS < 2 || N_TERMS > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("poly_term_sequencer: N_TERMS must be 2..8 and TIMEOUT >= 1");
  end

  localparam logic [2:0] LAST_K = 3'(N_TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_DONE
`ifdef WATCHDOG_EN
    ,
    S_ERROR
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic               busy_q, done_q, op_valid_q, acc_clr_q, acc_en_q, sel_acum_q;
  logic               busy_d, done_d, op_valid_d, acc_clr_d, acc_en_d, sel_acum_d;
  logic [CONST_W-1:0] sel_const_q, sel_const_d;
  logic [FUN_W-1:0]   sel_fun_q, sel_fun_d;

  function automatic logic [1:0] mod3(input logic [2:0] v);
    case (v)
      3'd0, 3'd3, 3'd6: mod3 = 2'd0;
      3'd1, 3'd4, 3'd7: mod3 = 2'd1;
      default:          mod3 = 2'd2;
    endcase
  endfunction

`ifdef WATCHDOG_EN
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wcnt_q;
  logic           err_q, err_d;
  logic           timeout_hit;
  assign timeout_hit = (wcnt_q == WCW'(TIMEOUT - 1));
`endif

  // Next state, term counter and next registered output values.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
`ifdef WATCHDOG_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE:  if (bus.start) begin
                 state_d = S_CLEAR;
                 k_d     = '0;
               end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.op_ack) state_d = S_ACCUM;
`ifdef WATCHDOG_EN
               else if (timeout_hit) state_d = S_ERROR;
`endif
      S_ACCUM: if (k_q == LAST_K) state_d = S_DONE;
               else begin
                 k_d     = k_q + 3'd1;
                 state_d = S_ISSUE;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort outranks every transition above, including op_ack and ACCUM->DONE
    if (bus.abort) begin
      state_d = S_IDLE;
      k_d     = '0;
    end
`ifdef WATCHDOG_EN
    if (state_d == S_ERROR) err_d = 1'b1;
    else if (state_d == S_CLEAR) err_d = 1'b0;
`endif
    // Moore outputs are registered from the next state so they align with it
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    op_valid_d  = (state_d == S_ISSUE);
    acc_clr_d   = (state_d == S_CLEAR);
    acc_en_d    = (state_d == S_ACCUM);
    sel_const_d = CONST_W'(k_d);
    sel_fun_d   = FUN_W'(mod3(k_d));
    sel_acum_d  = (k_d != 3'd0);
  end

  // State, term counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_valid_q  <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      sel_const_q <= '0;
      sel_fun_q   <= '0;
      sel_acum_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_valid_q  <= op_valid_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      sel_const_q <= sel_const_d;
      sel_fun_q   <= sel_fun_d;
      sel_acum_q  <= sel_acum_d;
    end
  end

`ifdef WATCHDOG_EN
  // WAIT-cycle counter (held at zero outside WAIT) and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q != S_WAIT) wcnt_q <= '0;
      else if (!bus.op_ack && !timeout_hit) wcnt_q <= wcnt_q + 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.sel_const = sel_const_q;
  assign bus.sel_fun   = sel_fun_q;
  assign bus.sel_acum  = sel_acum_q;
  assign bus.term_idx  = k_q;

endmodule
